// File: rtl/tile_sequencer.sv
// tile_sequencer: scrolling tile stream generator and key judge for the piano-tile game.
// Emits one 3-lane column per scroll step plus the display shift strobe, mirrors the
// on-screen columns in a 16-deep shadow and scores key presses against the oldest column.
module tile_sequencer #(
    parameter int          STEP_CYCLES = 2_500_000,
    parameter int          TILE_LEN    = 3,
    parameter int          GAP_LEN     = 1,
    parameter int          MAX_MISS    = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] key,
    output logic [2:0] data,
    output logic       div_clk,
    output logic [7:0] score,
    output logic       game_over
);

    localparam int            CW         = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] LAST       = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] HALF       = CW'(STEP_CYCLES / 2);
    localparam logic [2:0]    TILE_REM   = 3'(TILE_LEN - 1);
    localparam logic [2:0]    GAP_REM    = (GAP_LEN > 0) ? 3'(GAP_LEN - 1) : 3'd0;
    localparam logic [3:0]    MISS_LIMIT = 4'(MAX_MISS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OVER
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [15:0]     lfsr;
    logic [15:0][2:0] shadow;
    logic            zone_hit;
    logic [2:0]      key_d;
    logic [3:0]      miss;
    logic            tile_phase;
    logic [2:0]      remaining;
    logic [2:0]      lane;

    logic            enter_run;
    logic            gen_event;
    logic            shift_event;
    logic [2:0]      edges;
    logic [2:0]      zone;
    logic [2:0]      pick;
    logic            hit;
    logic            wrong;
    logic            leave_miss;
    logic            step_miss;

    assign game_over = (state == OVER);

    // Game state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start launches a game, reaching the miss limit ends it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (miss >= MISS_LIMIT) state_next = OVER;
            OVER:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Step timing, key judgement and lane selection for the current cycle.
    always_comb begin
        enter_run   = (state != RUN) && start;
        gen_event   = (count == LAST);
        shift_event = (count == HALF);
        count_next  = gen_event ? '0 : count + CW'(1);
        edges       = key & ~key_d;
        zone        = shadow[0];
        hit         = ((edges & zone) != 3'b000) && !zone_hit;
        wrong       = (edges & ~zone) != 3'b000;
        leave_miss  = shift_event && (zone != 3'b000) && !zone_hit && !hit;
        step_miss   = wrong || leave_miss;
        pick        = (lfsr[1:0] == 2'd3) ? 3'b001 : (3'b001 << lfsr[1:0]);
    end

    // Free-running lane randomiser; deliberately never reseeded between games.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Key history for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_d <= 3'b000;
        end else begin
            key_d <= key;
        end
    end

    // Scroll datapath: column generation, display shadow, scoring and miss tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            div_clk    <= 1'b0;
            data       <= 3'b000;
            score      <= 8'd0;
            miss       <= 4'd0;
            shadow     <= '0;
            zone_hit   <= 1'b0;
            tile_phase <= 1'b0;
            remaining  <= 3'd0;
            lane       <= 3'b000;
        end else if (enter_run) begin
            count      <= '0;
            div_clk    <= 1'b0;
            data       <= 3'b000;
            score      <= 8'd0;
            miss       <= 4'd0;
            shadow     <= '0;
            zone_hit   <= 1'b0;
            tile_phase <= 1'b0;
            remaining  <= 3'd0;
        end else if (state == RUN) begin
            if (state_next != RUN) begin
                data    <= 3'b000;
                div_clk <= 1'b0;
            end else begin
                count   <= count_next;
                div_clk <= (count_next >= HALF);
                if (gen_event) begin
                    if (remaining == 3'd0) begin
                        if (tile_phase && (GAP_LEN != 0)) begin
                            tile_phase <= 1'b0;
                            remaining  <= GAP_REM;
                            data       <= 3'b000;
                        end else begin
                            tile_phase <= 1'b1;
                            remaining  <= TILE_REM;
                            lane       <= pick;
                            data       <= pick;
                        end
                    end else begin
                        remaining <= remaining - 3'd1;
                        data      <= tile_phase ? lane : 3'b000;
                    end
                end
                if (shift_event) begin
                    shadow   <= {data, shadow[15:1]};
                    zone_hit <= 1'b0;
                end else if (hit) begin
                    zone_hit <= 1'b1;
                end
                if (hit && (score != 8'hFF)) begin
                    score <= score + 8'd1;
                end
                if (step_miss) begin
                    miss <= miss + 4'd1;
                end
            end
        end
    end

endmodule
